// File: rtl/poly_coef_packer.sv
// Packs a valid/ready stream of 12-bit coefficients into 96-bit words (8 lanes) and writes
// one 256-coefficient polynomial to RAM at a per-command word offset. Optional: COEF_REDUCE_EN.
module poly_coef_packer #(
  parameter int N_COEF = 256,
  parameter int COEF_W = 12,
  parameter int LANES  = 8,
  parameter int Q      = 3329,
  parameter int ADDR_W = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         w_offset,
  input  logic                      in_valid,
  input  logic [COEF_W-1:0]         in_coef,
  output logic                      in_ready,
  output logic                      ram_wen,
  output logic [ADDR_W-1:0]         ram_waddr,
  output logic [COEF_W*LANES-1:0]   ram_wdata,
  output logic                      busy,
  output logic                      done,
  output logic                      range_err
);

  localparam int LANE_BITS = $clog2(LANES);
  localparam int WORD_BITS = $clog2(N_COEF / LANES);
  localparam int CNT_W     = $clog2(N_COEF) + 1;

  typedef enum logic [1:0] {IDLE, FILL, LAST, DONE} state_t;

  state_t                   state, state_n;
  logic [CNT_W-1:0]         cnt;
  logic [ADDR_W-1:0]        offset;
  logic [COEF_W-1:0]        lane_q [LANES-1];
  logic [COEF_W-1:0]        coef_store;
  logic [COEF_W*LANES-1:0]  word_data;
  logic [LANE_BITS-1:0]     lane;
  logic [WORD_BITS-1:0]     word_idx;
  logic                     accept;
  logic                     out_of_range;
  logic                     last_coef;

  assign lane         = cnt[LANE_BITS-1:0];
  assign word_idx     = cnt[LANE_BITS+WORD_BITS-1:LANE_BITS];
  assign accept       = in_valid && in_ready;
  assign out_of_range = in_coef >= COEF_W'(Q);
  assign last_coef    = cnt == CNT_W'(N_COEF - 1);

`ifdef COEF_REDUCE_EN
  // A 12-bit value is below 2*Q, so a single conditional subtraction lands in [0, Q).
  assign coef_store = out_of_range ? in_coef - COEF_W'(Q) : in_coef;
`else
  assign coef_store = in_coef;
`endif

  // The final lane bypasses the holding register so the word is written the cycle after it arrives.
  always_comb begin
    word_data = '0;
    for (int k = 0; k < LANES - 1; k++) begin
      word_data[k*COEF_W +: COEF_W] = lane_q[k];
    end
    word_data[(LANES-1)*COEF_W +: COEF_W] = coef_store;
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: if (start) state_n = FILL;
      FILL: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && last_coef) state_n = LAST;
      end
      LAST: begin
        busy    = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      offset    <= '0;
      range_err <= 1'b0;
      ram_wen   <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
    end else begin
      state   <= state_n;
      ram_wen <= 1'b0;
      if (state == IDLE && start) begin
        offset    <= w_offset;
        cnt       <= '0;
        range_err <= 1'b0;
      end
      if (accept) begin
        cnt <= cnt + 1'b1;
        if (out_of_range) range_err <= 1'b1;
        if (lane == LANE_BITS'(LANES - 1)) begin
          ram_wen   <= 1'b1;
          ram_waddr <= offset + ADDR_W'(word_idx);
          ram_wdata <= word_data;
        end
      end
    end
  end

  // NOTE: the lane holding register has no reset; every lane is rewritten before each word goes out.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES - 1; k++) begin
      if (accept && lane == LANE_BITS'(k)) lane_q[k] <= coef_store;
    end
  end

endmodule

// File: tb/tb_poly_coef_packer.sv
// Self-checking bench for poly_coef_packer: table of polynomial runs checked through a write
// scoreboard, plus hand sequences for mid-stream reset.
module tb_poly_coef_packer;

  localparam int Q = 3329;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  w_offset;
  logic        in_valid;
  logic [11:0] in_coef;
  logic        in_ready;
  logic        ram_wen;
  logic [9:0]  ram_waddr;
  logic [95:0] ram_wdata;
  logic        busy;
  logic        done;
  logic        range_err;

  poly_coef_packer dut (
    .clk(clk), .rst(rst), .start(start), .w_offset(w_offset),
    .in_valid(in_valid), .in_coef(in_coef), .in_ready(in_ready),
    .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .busy(busy), .done(done), .range_err(range_err)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  typedef struct {
    logic [9:0]  addr;
    logic [95:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    logic [9:0]  offset;
    int          base;
    bit          gap;
    int          bad_idx;
    logic [11:0] bad_val;
    bit          mid_start;
    bit          exp_err;
  } vec_t;

  wr_t         exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          writes_seen = 0;
  int          done_cnt = 0;
  logic [9:0]  first_addr, last_addr;
  logic [95:0] first_data;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [11:0] reduce(input logic [11:0] c);
`ifdef COEF_REDUCE_EN
    return (c >= 12'(Q)) ? c - 12'(Q) : c;
`else
    return c;
`endif
  endfunction

  // Write monitor: every RAM write must match the oldest scoreboard entry, including its cycle.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && ram_wen) begin
      if (writes_seen == 0) begin
        first_addr = ram_waddr;
        first_data = ram_wdata;
      end
      last_addr = ram_waddr;
      writes_seen++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: addr %0d data %0h with none expected", ram_waddr, ram_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", ram_waddr, e.addr);
        check("write_data", ram_wdata, e.data);
        check("write_cycle", cycle, e.cyc);
      end
    end
    if (!rst && done) done_cnt++;
  end

  // Drives one polynomial; stops early (no end checks) once abort_at coefficients are accepted.
  task automatic run_poly(input vec_t v, input int abort_at);
    logic [11:0] lanes [8];
    logic [95:0] word;
    logic [11:0] c;
    int idx = 0, guard = 0, last_cyc = 0, g = 0;
    bit phase = 1'b0, got_done = 1'b0;
    writes_seen = 0;
    done_cnt    = 0;
    @(posedge clk); #1;
    start    = 1'b1;
    w_offset = v.offset;
    in_valid = 1'b1;
    in_coef  = (v.bad_idx == 0) ? v.bad_val : 12'(v.base % Q);
    @(negedge clk);
    check("ready_low_in_idle", in_ready, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("range_err_cleared", range_err, 1'b0);
    while (idx < 256 && guard < 2000) begin
      if (idx == abort_at) break;
      c        = (v.bad_idx == idx) ? v.bad_val : 12'((idx + v.base) % Q);
      in_valid = v.gap ? phase : 1'b1;
      phase    = ~phase;
      in_coef  = c;
      start    = v.mid_start && idx == 50;
      if (start) w_offset = v.offset + 10'd7;
      @(negedge clk);
      if (in_valid && in_ready) begin
        lanes[idx % 8] = reduce(c);
        if (idx % 8 == 7) begin
          for (int k = 0; k < 8; k++) word[k*12 +: 12] = lanes[k];
          exp_q.push_back('{addr: v.offset + 10'(idx / 8), data: word, cyc: cycle + 1});
          last_cyc = cycle + 1;
        end
        idx++;
      end
      guard++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (idx == abort_at) return;
    in_valid = 1'b0;
    check("stream_accepted", idx, 256);
    @(negedge clk);
    check("ready_drops_after_last", in_ready, 1'b0);
    while (g < 20 && !got_done) begin
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
        check("done_latency", cycle, last_cyc + 1);
        check("busy_low_at_done", busy, 1'b0);
      end
      g++;
    end
    check("done_seen", got_done, 1'b1);
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("write_count", writes_seen, 32);
    check("scoreboard_empty", exp_q.size(), 0);
    check("range_err_sticky", range_err, v.exp_err);
    check("busy_idle", busy, 1'b0);
  endtask

  initial begin
    vec_t vecs[6];
    vec_t rv;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vec_t rv;
    vecs[0] = '{offset: 10'd64,   base: 0,    gap: 1'b0, bad_idx: -1,  bad_val: 12'd0,    mid_start: 1'b0, exp_err: 1'b0};
    vecs[1] = '{offset: 10'd64,   base: 0,    gap: 1'b1, bad_idx: -1,  bad_val: 12'd0,    mid_start: 1'b0, exp_err: 1'b0};
    vecs[2] = '{offset: 10'd1010, base: 1000, gap: 1'b0, bad_idx: -1,  bad_val: 12'd0,    mid_start: 1'b0, exp_err: 1'b0};
    vecs[3] = '{offset: 10'd0,    base: 0,    gap: 1'b0, bad_idx: 5,   bad_val: 12'd3329, mid_start: 1'b0, exp_err: 1'b1};
    vecs[4] = '{offset: 10'd300,  base: 3200, gap: 1'b1, bad_idx: 200, bad_val: 12'd4095, mid_start: 1'b0, exp_err: 1'b1};
    vecs[5] = '{offset: 10'd64,   base: 77,   gap: 1'b0, bad_idx: -1,  bad_val: 12'd0,    mid_start: 1'b1, exp_err: 1'b0};

    rst = 1'b1; start = 1'b0; w_offset = '0; in_valid = 1'b0; in_coef = '0;
    #1;
    check("reset_outputs", {in_ready, ram_wen, busy, done, range_err, ram_waddr, ram_wdata}, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_poly(vecs[i], -1);
      if (i == 0) check("word0_packing", first_data, 96'h007006005004003002001000);
      if (i == 2) begin
        check("wrap_first_addr", first_addr, 10'd1010);
        check("wrap_last_addr", last_addr, 10'd17);
      end
`ifdef COEF_REDUCE_EN
      if (i == 3) check("lane5_q_value", first_data[71:60], 12'h000);
`else
      if (i == 3) check("lane5_q_value", first_data[71:60], 12'hD01);
`endif
    end

    // Reset after 100 coefficients: outputs clear at once, partial word is never written.
    rv = '{offset: 10'd5, base: 11, gap: 1'b0, bad_idx: 3, bad_val: 12'd4000, mid_start: 1'b0, exp_err: 1'b1};
    run_poly(rv, 100);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", {in_ready, ram_wen, busy, done, range_err, ram_waddr, ram_wdata}, '0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    writes_seen = 0;
    repeat (10) @(negedge clk);
    check("no_write_after_reset", writes_seen, 0);
    check("reset_scoreboard_empty", exp_q.size(), 0);
    run_poly(vecs[1], -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
